bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning slave-wait cycles before abort (legal range 2..255).
REQ-002 SHALL have port clk  input  1  system clock, rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-004 SHALL have port m_req_i  input  3  per-master request; bit0 = ex load/store, bit1 = instruction fetch, bit2 = debug.
REQ-005 SHALL have port m_we_i  input  3  per-master write enable.
REQ-006 SHALL have port m_addr_i  input  96  packed per-master address; master k uses bits [32k+31:32k].
REQ-007 SHALL have port m_wdata_i  input  96  packed per-master write data, same packing as m_addr_i.
REQ-008 SHALL have port m_ack_o  output  3  per-master one-cycle completion pulse.
REQ-009 SHALL have port m_rdata_o  output  32  read data, valid while any m_ack_o bit is high.
REQ-010 SHALL have port err_o  output  1  one-cycle pulse with m_ack_o when a timeout aborts the transaction.
REQ-011 SHALL have ports s_req_o output 1 slave request, s_we_o output 1 slave write enable, s_addr_o output 32 slave address, s_wdata_o output 32 slave write data.
REQ-012 SHALL have ports s_ack_i input 1 slave done and s_rdata_i input 32 slave read data.
REQ-013 SHALL have port grant_o  output  2  index of the owning master, valid while busy_o is high.
REQ-014 SHALL have port busy_o  output  1  high while in state BUSY.

Function
REQ-015 SHALL implement two states, IDLE and BUSY; all outputs SHALL be registered.
REQ-016 In IDLE, SHALL arbitrate among the eligible requesters; master k is eligible when m_req_i[k]=1 and m_ack_o[k]=0.
REQ-017 Default priority SHALL be fixed: master 0 over master 1 over master 2.
REQ-018 On a winner, SHALL capture its we/addr/wdata into the s_* outputs, set s_req_o=1, set grant_o, clear the wait counter and enter BUSY on the same edge (one-cycle arbitration latency).
REQ-019 In BUSY, s_req_o and the s_* fields SHALL hold stable until completion; the 8-bit wait counter SHALL increment each cycle.
REQ-020 When s_ack_i=1 is sampled in BUSY, SHALL:
- pulse m_ack_o[grant] for exactly one cycle;
- register s_rdata_i into m_rdata_o (0 on writes);
- drop s_req_o;
- return to IDLE.
REQ-021 When the counter reaches TIMEOUT-1 without s_ack_i, SHALL pulse m_ack_o[grant] and err_o together, set m_rdata_o=0, drop s_req_o and return to IDLE.
REQ-022 If s_ack_i and timeout occur in the same cycle, s_ack_i SHALL win: normal completion with err_o=0.
REQ-023 If a master drops its request during BUSY, the transaction SHALL still complete and m_ack_o SHALL still pulse.
REQ-024 Outside completion cycles, m_ack_o, err_o and m_rdata_o SHALL be 0; s_ack_i in IDLE SHALL be ignored.
REQ-025 Minimum back-to-back period per transaction SHALL be 3 cycles: grant, slave ack sampled, ack/IDLE cycle.

Reset
REQ-026 Reset assertion SHALL immediately force, without waiting for a clock edge:
- state=IDLE;
- s_req_o=0, s_we_o=0, s_addr_o=0, s_wdata_o=0;
- m_ack_o=0, m_rdata_o=0, err_o=0;
- grant_o=0, busy_o=0, counter=0.
REQ-027 Reset during BUSY SHALL abandon the transaction with no ack or err pulse after release.
REQ-028 The first arbitration SHALL occur on the first rising edge after reset deassertion.

Configuration
REQ-029 With macro BUS_ARB_ROUND_ROBIN_EN defined:
- priority SHALL rotate, starting at the master after the last-served one;
- the last-served pointer SHALL update at each completion, including timeouts;
- the pointer SHALL reset to 2, so master 0 has first priority.
REQ-030 Without BUS_ARB_ROUND_ROBIN_EN, the fixed priority of REQ-017 SHALL apply and no pointer logic SHALL exist.

Verification
REQ-031 Master 1 reads 0x100; slave acks 2 cycles after s_req_o with rdata 0xDEADBEEF -> s_addr_o=0x100, s_we_o=0, grant_o=1, m_ack_o=3'b010 for one cycle, m_rdata_o=0xDEADBEEF.
REQ-032 Masters 0, 1 and 2 request simultaneously and continuously:
- fixed mode -> grant order 0,0,0,...; master 1 is starved;
- round-robin mode -> grant order 0,1,2,0.
REQ-033 TIMEOUT=4, master 2 writes 0x55 to 0x20 and slave never acks -> s_req_o high for exactly 4 cycles, then m_ack_o=3'b100 with err_o=1 and m_rdata_o=0.
REQ-034 TIMEOUT=4, s_ack_i asserted in the counter=3 cycle -> normal ack with err_o=0.
REQ-035 rst driven low mid-BUSY between clock edges -> s_req_o and busy_o go 0 immediately; after release, no m_ack_o pulse appears.
REQ-036 Master 0 holds m_req_i high through its ack cycle with no other requester -> no re-grant in the ack cycle; master 0 is re-granted on the following edge.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: three-master to one-slave bus arbiter with slave-wait timeout abort.
// Define BUS_ARB_ROUND_ROBIN_EN for rotating priority instead of fixed 0 > 1 > 2.
module bus_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  m_req_i,
  input  logic [2:0]  m_we_i,
  input  logic [95:0] m_addr_i,
  input  logic [95:0] m_wdata_i,
  output logic [2:0]  m_ack_o,
  output logic [31:0] m_rdata_o,
  output logic        err_o,
  output logic        s_req_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_rdata_i,
  output logic [1:0]  grant_o,
  output logic        busy_o
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);
  state_t     r_state;
  logic [7:0] r_cnt;
  logic [2:0] w_elig;
  logic [1:0] w_win;
  logic       w_start;
  logic       w_done;
  assign w_elig = m_req_i & ~m_ack_o;
  // The ack cycle is dead for arbitration, so every transaction takes at least 3 cycles
  assign w_start = r_state == IDLE && ~|m_ack_o && |w_elig;
  assign w_done = r_state == BUSY && (s_ack_i || r_cnt == LAST_WAIT);
`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic [1:0] r_last;
  logic [1:0] w_p0;
  logic [1:0] w_p1;
  logic [1:0] w_p2;
  assign w_p0 = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
  assign w_p1 = (w_p0 == 2'd2) ? 2'd0 : w_p0 + 2'd1;
  assign w_p2 = (w_p1 == 2'd2) ? 2'd0 : w_p1 + 2'd1;
  assign w_win = w_elig[w_p0] ? w_p0 : w_elig[w_p1] ? w_p1 : w_p2;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_last <= 2'd2;
    else if (w_done) r_last <= grant_o;
  end
`else
  assign w_win = w_elig[0] ? 2'd0 : w_elig[1] ? 2'd1 : 2'd2;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      s_req_o   <= 1'b0;
      s_we_o    <= 1'b0;
      s_addr_o  <= '0;
      s_wdata_o <= '0;
      m_ack_o   <= '0;
      m_rdata_o <= '0;
      err_o     <= 1'b0;
      grant_o   <= '0;
      busy_o    <= 1'b0;
    end else begin
      m_ack_o   <= '0;
      m_rdata_o <= '0;
      err_o     <= 1'b0;
      if (w_start) begin
        r_state   <= BUSY;
        busy_o    <= 1'b1;
        s_req_o   <= 1'b1;
        s_we_o    <= m_we_i[w_win];
        s_addr_o  <= m_addr_i[{w_win, 5'd0} +: 32];
        s_wdata_o <= m_wdata_i[{w_win, 5'd0} +: 32];
        grant_o   <= w_win;
        r_cnt     <= '0;
      end else if (w_done) begin
        r_state   <= IDLE;
        busy_o    <= 1'b0;
        s_req_o   <= 1'b0;
        m_ack_o   <= 3'b001 << grant_o;
        err_o     <= ~s_ack_i;
        m_rdata_o <= (s_ack_i && !s_we_o) ? s_rdata_i : '0;
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios plus randomized traffic checked against a transaction model.
module tb_bus_arbiter;
  localparam int TO = 4;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  m_req_i;
  logic [2:0]  m_we_i;
  logic [95:0] m_addr_i;
  logic [95:0] m_wdata_i;
  logic [2:0]  m_ack_o;
  logic [31:0] m_rdata_o;
  logic        err_o;
  logic        s_req_o;
  logic        s_we_o;
  logic [31:0] s_addr_o;
  logic [31:0] s_wdata_o;
  logic        s_ack_i;
  logic [31:0] s_rdata_i;
  logic [1:0]  grant_o;
  logic        busy_o;
  int n_checks = 0;
  int n_errors = 0;
  bit          e_busy;
  int          e_owner;
  int          e_wait;
  int          e_last;
  logic [2:0]  e_ack;
  logic        e_err;
  logic        e_we;
  logic [31:0] e_rdata;
  logic [31:0] e_addr;
  logic [31:0] e_wdata;
  logic [1:0]  order [4];

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m_req_i(m_req_i), .m_we_i(m_we_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
    .m_ack_o(m_ack_o), .m_rdata_o(m_rdata_o), .err_o(err_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_ack_i(s_ack_i), .s_rdata_i(s_rdata_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic quiet();
    m_req_i = '0; m_we_i = '0; m_addr_i = '0; m_wdata_i = '0;
    s_ack_i = 1'b0; s_rdata_i = '0;
  endtask

  task automatic model_reset();
    e_busy = 0; e_owner = 0; e_wait = 0; e_last = 2;
    e_ack = '0; e_err = 0; e_we = 0; e_rdata = '0; e_addr = '0; e_wdata = '0;
  endtask

  // Advances the model by one clock using the inputs that the coming edge will sample.
  task automatic model_step();
    logic [2:0] prev_ack;
    int won;
    prev_ack = e_ack;
    e_ack = '0; e_err = 0; e_rdata = '0;
    won = -1;
    if (!e_busy) begin
      if (prev_ack == 0) begin
        for (int i = 0; i < 3; i++) begin
          int k;
`ifdef BUS_ARB_ROUND_ROBIN_EN
          k = (e_last + 1 + i) % 3;
`else
          k = i;
`endif
          if (won < 0 && m_req_i[k]) won = k;
        end
        if (won >= 0) begin
          e_busy = 1; e_owner = won; e_wait = 0;
          e_we = m_we_i[won];
          e_addr = m_addr_i[32*won +: 32];
          e_wdata = m_wdata_i[32*won +: 32];
        end
      end
    end else if (s_ack_i) begin
      e_ack = 3'(1 << e_owner);
      e_rdata = e_we ? 32'h0 : s_rdata_i;
      e_busy = 0; e_last = e_owner;
    end else if (e_wait == TO - 1) begin
      e_ack = 3'(1 << e_owner);
      e_err = 1;
      e_busy = 0; e_last = e_owner;
    end else begin
      e_wait++;
    end
  endtask

  initial begin
    quiet();
    rst = 1'b0;
    #1;
    chk("rst_sreq", s_req_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ack", m_ack_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rdata", m_rdata_o, 0);
    chk("rst_grant", grant_o, 0);
    chk("rst_saddr", s_addr_o, 0);
    @(negedge clk);
    rst = 1'b1;

    // all masters request continuously, slave always ready
`ifdef BUS_ARB_ROUND_ROBIN_EN
    order = '{2'd0, 2'd1, 2'd2, 2'd0};
`else
    order = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif
    m_req_i = 3'b111; s_ack_i = 1'b1; s_rdata_i = 32'hA5A5_0001;
    m_addr_i = {32'h2000, 32'h1000, 32'h0};
    for (int g = 0; g < 4; g++) begin
      cyc();
      chk("prio_busy", busy_o, 1);
      chk("prio_grant", grant_o, order[g]);
      if (g < 3) begin
        cyc();
        chk("prio_ack", m_ack_o, 32'(1 << order[g]));
        chk("prio_rdata", m_rdata_o, 32'hA5A5_0001);
        cyc();
        chk("prio_dead", busy_o, 0);
      end
    end
    m_req_i = '0;
    cyc();
    chk("prio_last_ack", m_ack_o, 32'(1 << order[3]));
    s_ack_i = 1'b0;
    cyc();
    chk("prio_ack_clr", m_ack_o, 0);

    // master 1 read with slave ack two cycles after request
    m_req_i = 3'b010; m_we_i = '0; m_addr_i = {32'h0, 32'h100, 32'h0};
    cyc();
    chk("rd_sreq", s_req_o, 1);
    chk("rd_saddr", s_addr_o, 32'h100);
    chk("rd_swe", s_we_o, 0);
    chk("rd_grant", grant_o, 1);
    chk("rd_busy", busy_o, 1);
    m_req_i = '0; s_rdata_i = 32'hDEAD_BEEF;
    cyc();
    chk("rd_wait_ack", m_ack_o, 0);
    chk("rd_wait_sreq", s_req_o, 1);
    s_ack_i = 1'b1;
    cyc();
    chk("rd_ack", m_ack_o, 3'b010);
    chk("rd_rdata", m_rdata_o, 32'hDEAD_BEEF);
    chk("rd_err", err_o, 0);
    chk("rd_sreq_drop", s_req_o, 0);
    chk("rd_idle", busy_o, 0);
    s_ack_i = 1'b0;
    cyc();
    chk("rd_ack_clr", m_ack_o, 0);
    chk("rd_rdata_clr", m_rdata_o, 0);

    // master 2 write, slave never acks
    m_req_i = 3'b100; m_we_i = 3'b100;
    m_addr_i = {32'h20, 64'h0}; m_wdata_i = {32'h55, 64'h0}; s_rdata_i = 32'hFFFF_FFFF;
    cyc();
    chk("to_sreq0", s_req_o, 1);
    chk("to_swe", s_we_o, 1);
    chk("to_saddr", s_addr_o, 32'h20);
    chk("to_swdata", s_wdata_o, 32'h55);
    chk("to_grant", grant_o, 2);
    m_req_i = '0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("to_sreq_hold", s_req_o, 1);
      chk("to_no_ack", m_ack_o, 0);
    end
    cyc();
    chk("to_ack", m_ack_o, 3'b100);
    chk("to_err", err_o, 1);
    chk("to_rdata", m_rdata_o, 0);
    chk("to_sreq_drop", s_req_o, 0);
    cyc();
    chk("to_err_clr", err_o, 0);
    chk("to_ack_clr", m_ack_o, 0);

    // slave ack arrives in the last wait cycle
    m_req_i = 3'b001; m_we_i = '0; m_addr_i = {64'h0, 32'h44};
    cyc();
    chk("late_grant", grant_o, 0);
    m_req_i = '0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("late_no_ack", m_ack_o, 0);
    end
    s_ack_i = 1'b1; s_rdata_i = 32'h1234_5678;
    cyc();
    chk("late_ack", m_ack_o, 3'b001);
    chk("late_err", err_o, 0);
    chk("late_rdata", m_rdata_o, 32'h1234_5678);
    s_ack_i = 1'b0;
    cyc();

    // master 0 holds request through its ack cycle
    m_req_i = 3'b001; s_ack_i = 1'b1; s_rdata_i = 32'hCAFE;
    cyc();
    chk("hold_busy0", busy_o, 1);
    chk("hold_grant0", grant_o, 0);
    cyc();
    chk("hold_ack0", m_ack_o, 3'b001);
    cyc();
    chk("hold_no_regrant", busy_o, 0);
    chk("hold_no_sreq", s_req_o, 0);
    cyc();
    chk("hold_regrant", busy_o, 1);
    chk("hold_grant1", grant_o, 0);
    cyc();
    chk("hold_ack1", m_ack_o, 3'b001);
    m_req_i = '0; s_ack_i = 1'b0;
    cyc();

    // reset in the middle of a transaction
    m_req_i = 3'b010;
    cyc();
    chk("mrst_busy", busy_o, 1);
    m_req_i = '0;
    #2;
    rst = 1'b0;
    #1;
    chk("mrst_sreq", s_req_o, 0);
    chk("mrst_busy_clr", busy_o, 0);
    chk("mrst_ack", m_ack_o, 0);
    @(negedge clk);
    rst = 1'b1; s_ack_i = 1'b1;
    cyc();
    chk("mrst_no_ack", m_ack_o, 0);
    chk("mrst_no_err", err_o, 0);
    cyc();
    chk("mrst_no_ack2", m_ack_o, 0);
    s_ack_i = 1'b0;

    // randomized traffic against the model
    rst = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 500; n++) begin
      chk("rnd_ack", m_ack_o, e_ack);
      chk("rnd_err", err_o, e_err);
      chk("rnd_rdata", m_rdata_o, e_rdata);
      chk("rnd_busy", busy_o, e_busy);
      chk("rnd_sreq", s_req_o, e_busy);
      if (e_busy) begin
        chk("rnd_grant", grant_o, e_owner);
        chk("rnd_swe", s_we_o, e_we);
        chk("rnd_saddr", s_addr_o, e_addr);
        chk("rnd_swdata", s_wdata_o, e_wdata);
      end
      m_req_i = 3'($urandom_range(0, 7));
      m_we_i = 3'($urandom_range(0, 7));
      m_addr_i = {$urandom, $urandom, $urandom};
      m_wdata_i = {$urandom, $urandom, $urandom};
      s_ack_i = ($urandom_range(0, 9) < 4);
      s_rdata_i = $urandom;
      model_step();
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
